// File: rtl/modulation_bram_writer_pkg.sv
// Shared types and constants for the modulation BRAM write path.
package modulation_bram_writer_pkg;

    localparam int unsigned NumSegment       = 2;
    localparam int unsigned SegIdxWidth      = 15;
    localparam int unsigned ModWordAddrWidth = 14;

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI,
        FILL
    } mod_writer_state_t;

    typedef struct packed {
        logic                        segment;
        logic [ModWordAddrWidth-1:0] addr;
        logic [15:0]                 data;
    } mod_wr_word_t;

    localparam int unsigned ModWordWidth = $bits(mod_wr_word_t);

endpackage

// File: rtl/modulation_bram_writer_fifo.sv
// mod_word_fifo: small synchronous FIFO holding host words (mod_wr_word_t)
// between the host handshake and the BRAM write sequencer. Head word is
// presented combinationally on dout.
module mod_word_fifo
    import modulation_bram_writer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [ModWordWidth-1:0] din,
    input  logic                    pop,
    output logic [ModWordWidth-1:0] dout,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [ModWordWidth-1:0] mem [DEPTH];
    logic [PtrW:0]           wr_ptr;
    logic [PtrW:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                     (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign dout    = mem[rd_ptr[PtrW-1:0]];

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PtrW-1:0]] <= din;
        end
    end

    // Read/write pointers with one wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/modulation_bram_writer.sv
// modulation_bram_writer: splits host 16-bit words into two BRAM byte writes,
// provides a whole-segment fill engine and per-segment high-water marks.
// Optional write statistics: define MODULATION_BRAM_WRITER_STATS_EN.
module modulation_bram_writer
    import modulation_bram_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SEG_IDX_W  = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WR_VALID,
    output logic                   WR_READY,
    input  logic                   WR_SEGMENT,
    input  logic [SEG_IDX_W-2:0]   WR_ADDR,
    input  logic [15:0]            WR_DATA,
    input  logic                   FILL_REQ,
    input  logic                   FILL_SEGMENT,
    input  logic [7:0]             FILL_VALUE,
    output logic                   FILL_BUSY,
    output logic                   BRAM_WE,
    output logic [SEG_IDX_W:0]     BRAM_ADDR,
    output logic [7:0]             BRAM_DIN,
    output logic [2*SEG_IDX_W-1:0] MAX_IDX,
    output logic [31:0]            WRITE_COUNT
);

    mod_writer_state_t       state;
    mod_writer_state_t       state_next;
    mod_wr_word_t            word;
    logic [ModWordWidth-1:0] fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    ready_en;
    logic                    fill_pending;
    logic                    fill_seg;
    logic [7:0]              fill_value;
    logic [SEG_IDX_W-1:0]    fill_idx;
    logic [SEG_IDX_W-1:0]    max0;
    logic [SEG_IDX_W-1:0]    max1;
    logic [SEG_IDX_W-1:0]    hi_idx;
    logic                    we_next;
    logic [SEG_IDX_W:0]      addr_next;
    logic [7:0]              din_next;

    assign WR_READY  = ready_en && !fifo_full && !fill_pending && (state != FILL);
    assign push      = WR_VALID && WR_READY;
    assign FILL_BUSY = fill_pending;
    assign MAX_IDX   = {max1, max0};
    assign hi_idx    = {word.addr, 1'b1};

    mod_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (CLK),
        .rst  (RST),
        .push (push),
        .din  ({WR_SEGMENT, WR_ADDR, WR_DATA}),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Next-state, FIFO pop and next BRAM port values.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        we_next    = 1'b0;
        addr_next  = '0;
        din_next   = '0;
        case (state)
            IDLE: begin
                if (fill_pending && fifo_empty) begin
                    state_next = FILL;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = WR_LO;
                end
            end
            WR_LO: begin
                we_next    = 1'b1;
                addr_next  = {word.segment, word.addr, 1'b0};
                din_next   = word.data[7:0];
                state_next = WR_HI;
            end
            WR_HI: begin
                we_next   = 1'b1;
                addr_next = {word.segment, word.addr, 1'b1};
                din_next  = word.data[15:8];
                if (!fifo_empty && !fill_pending) begin
                    pop        = 1'b1;
                    state_next = WR_LO;
                end else begin
                    state_next = IDLE;
                end
            end
            FILL: begin
                we_next   = 1'b1;
                addr_next = {fill_seg, fill_idx};
                din_next  = fill_value;
                if (fill_idx == '1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and the word currently being written.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            word     <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            if (pop) begin
                word <= mod_wr_word_t'(fifo_dout);
            end
        end
    end

    // Fill request capture and fill index; requests while busy are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill_pending <= 1'b0;
            fill_seg     <= 1'b0;
            fill_value   <= '0;
            fill_idx     <= '0;
        end else begin
            if (state == FILL && fill_idx == '1) begin
                fill_pending <= 1'b0;
            end else if (FILL_REQ && !fill_pending) begin
                fill_pending <= 1'b1;
                fill_seg     <= FILL_SEGMENT;
                fill_value   <= FILL_VALUE;
            end
            fill_idx <= (state == FILL) ? fill_idx + 1'b1 : '0;
        end
    end

    // Per-segment high-water marks: raised by the odd-sample write, cleared on fill entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            max0 <= '0;
            max1 <= '0;
        end else if (state == WR_HI) begin
            if (!word.segment && hi_idx > max0) max0 <= hi_idx;
            if (word.segment && hi_idx > max1)  max1 <= hi_idx;
        end else if (state == IDLE && state_next == FILL) begin
            if (!fill_seg) max0 <= '0;
            else           max1 <= '0;
        end
    end

    // Registered BRAM port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BRAM_WE   <= 1'b0;
            BRAM_ADDR <= '0;
            BRAM_DIN  <= '0;
        end else begin
            BRAM_WE   <= we_next;
            BRAM_ADDR <= addr_next;
            BRAM_DIN  <= din_next;
        end
    end

`ifdef MODULATION_BRAM_WRITER_STATS_EN
    // Count every cycle the BRAM strobe is high, wrapping at 2^32.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WRITE_COUNT <= '0;
        end else if (BRAM_WE) begin
            WRITE_COUNT <= WRITE_COUNT + 1'b1;
        end
    end
`else
    assign WRITE_COUNT = '0;
`endif

endmodule

// File: tb/tb_modulation_bram_writer.sv
// Testbench for modulation_bram_writer: directed vector table plus hand-written
// burst, fill, and reset-during-fill sequences.
module tb_modulation_bram_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        wr_segment = 1'b0;
    logic [13:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        fill_req = 1'b0;
    logic        fill_segment = 1'b0;
    logic [7:0]  fill_value = '0;
    logic        fill_busy;
    logic        bram_we;
    logic [15:0] bram_addr;
    logic [7:0]  bram_din;
    logic [29:0] max_idx;
    logic [31:0] write_count;

    modulation_bram_writer #(
        .FIFO_DEPTH(4),
        .SEG_IDX_W (15)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .WR_VALID    (wr_valid),
        .WR_READY    (wr_ready),
        .WR_SEGMENT  (wr_segment),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .FILL_REQ    (fill_req),
        .FILL_SEGMENT(fill_segment),
        .FILL_VALUE  (fill_value),
        .FILL_BUSY   (fill_busy),
        .BRAM_WE     (bram_we),
        .BRAM_ADDR   (bram_addr),
        .BRAM_DIN    (bram_din),
        .MAX_IDX     (max_idx),
        .WRITE_COUNT (write_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every observed BRAM write with its cycle stamp.
    typedef struct {
        int unsigned stamp;
        logic [15:0] addr;
        logic [7:0]  din;
    } wr_rec_t;
    wr_rec_t wq[$];
    wr_rec_t mon_rec;
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            mon_rec.stamp = cyc;
            mon_rec.addr  = bram_addr;
            mon_rec.din   = bram_din;
            wq.push_back(mon_rec);
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] wc_exp(input int unsigned n);
`ifdef MODULATION_BRAM_WRITER_STATS_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic seg, input logic [13:0] addr,
                             input logic [15:0] data, output int stalls);
        bit got;
        bit rdy;
        got    = 1'b0;
        stalls = 0;
        wr_valid   = 1'b1;
        wr_segment = seg;
        wr_addr    = addr;
        wr_data    = data;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            rdy = wr_ready;
            @(posedge clk);
            #1;
            if (rdy) got = 1'b1;
            else stalls++;
        end
        wr_valid = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL send_word_timeout: wr_ready=0 expected 1");
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        seg;
        logic [13:0] addr;
        logic [15:0] data;
        logic [15:0] a_lo;
        logic [7:0]  d_lo;
        logic [15:0] a_hi;
        logic [7:0]  d_hi;
        logic [29:0] max_exp;
    } vec_t;

    vec_t        vt[5];
    int          st;
    int          stalls_total;
    int          errs;
    int          bad_ready;
    bit          done;
    int unsigned exp_wc;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic [31:0] gap;

    initial begin
        // seg, addr, data, lo addr/byte, hi addr/byte, expected {max1,max0}
        vt[0] = '{1'b0, 14'h0005, 16'hBEEF, 16'h000A, 8'hEF, 16'h000B, 8'hBE, {15'd0,     15'd11}};
        vt[1] = '{1'b1, 14'h3FFF, 16'h1234, 16'hFFFE, 8'h34, 16'hFFFF, 8'h12, {15'd32767, 15'd11}};
        vt[2] = '{1'b0, 14'h0003, 16'hA55A, 16'h0006, 8'h5A, 16'h0007, 8'hA5, {15'd32767, 15'd11}};
        vt[3] = '{1'b0, 14'h0100, 16'h00FF, 16'h0200, 8'hFF, 16'h0201, 8'h00, {15'd32767, 15'd513}};
        vt[4] = '{1'b1, 14'h0000, 16'h7F80, 16'h8000, 8'h80, 16'h8001, 8'h7F, {15'd32767, 15'd513}};
        exp_wc = 0;

        // Reset state
        @(negedge clk);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_fill_busy", fill_busy, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_bram_din", bram_din, 0);
        check("rst_max_idx", max_idx, 0);
        check("rst_write_count", write_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", wr_ready, 1);
        tick(1);

        // Single-word vectors with exact write timing
        for (int i = 0; i < 5; i++) begin
            send_word(vt[i].seg, vt[i].addr, vt[i].data, st);
            @(negedge clk); check($sformatf("vec%0d_c0_we", i), bram_we, 0);
            @(negedge clk); check($sformatf("vec%0d_c1_we", i), bram_we, 0);
            @(negedge clk); check($sformatf("vec%0d_lo", i), {bram_we, bram_addr, bram_din},
                                  {1'b1, vt[i].a_lo, vt[i].d_lo});
            @(negedge clk); check($sformatf("vec%0d_hi", i), {bram_we, bram_addr, bram_din},
                                  {1'b1, vt[i].a_hi, vt[i].d_hi});
            @(negedge clk); check($sformatf("vec%0d_post_we", i), bram_we, 0);
            check($sformatf("vec%0d_max_idx", i), max_idx, vt[i].max_exp);
            exp_wc += 2;
            tick(1);
        end
        check("wc_after_table", write_count, wc_exp(exp_wc));

        // Nine-word burst: FIFO fills, WR_READY stalls exactly twice
        wq.delete();
        stalls_total = 0;
        for (int k = 0; k < 9; k++) begin
            send_word(1'b0, 14'(14'h10 + k), {8'(8'h90 + k), 8'(8'h80 + k)}, st);
            stalls_total += st;
        end
        tick(20);
        check("burst9_stalls", stalls_total, 2);
        check("burst9_count", wq.size(), 18);
        errs = 0;
        for (int j = 0; j < wq.size() && j < 18; j++) begin
            ea = 16'(2 * (16'h10 + j / 2) + j % 2);
            ed = (j % 2 == 0) ? 8'(8'h80 + j / 2) : 8'(8'h90 + j / 2);
            if (wq[j].addr !== ea || wq[j].din !== ed) errs++;
        end
        check("burst9_data", errs, 0);
        check("burst9_max_idx", max_idx, {15'd32767, 15'd513});
        exp_wc += 18;

        // Fill seg0 with 0xFF behind three queued words; second request ignored
        wq.delete();
        for (int k = 0; k < 3; k++) begin
            send_word(1'b0, 14'(14'h20 + k), {8'(k + 1), 8'(k + 1)}, st);
        end
        fill_req = 1'b1; fill_segment = 1'b0; fill_value = 8'hFF;
        @(posedge clk);
        #1 fill_req = 1'b0;
        @(negedge clk);
        check("fill_busy_rise", fill_busy, 1);
        bad_ready = 0;
        done = 1'b0;
        for (int c = 0; c < 40000 && !done; c++) begin
            @(negedge clk);
            if (!fill_busy) begin
                done = 1'b1;
            end else begin
                if (wr_ready) bad_ready++;
                if (c == 200) begin
                    fill_req = 1'b1; fill_segment = 1'b1; fill_value = 8'h00;
                end else begin
                    fill_req = 1'b0;
                end
            end
        end
        fill_req = 1'b0;
        check("fill_completes", done, 1);
        check("fill_ready_low", bad_ready, 0);
        tick(40);
        check("fill_total_writes", wq.size(), 6 + 32768);
        errs = 0;
        for (int j = 0; j < wq.size() && j < 6; j++) begin
            ea = 16'(2 * (16'h20 + j / 2) + j % 2);
            ed = 8'(j / 2 + 1);
            if (wq[j].addr !== ea || wq[j].din !== ed) errs++;
        end
        check("fill_data_first", errs, 0);
        errs = 0;
        for (int j = 6; j < wq.size() && j < 6 + 32768; j++) begin
            if (wq[j].addr !== 16'(j - 6) || wq[j].din !== 8'hFF) errs++;
        end
        check("fill_contents", errs, 0);
        check("fill_busy_fall", fill_busy, 0);
        check("fill_max_idx", max_idx, {15'd32767, 15'd0});
        exp_wc += 6 + 32768;
        check("wc_after_fill", write_count, wc_exp(exp_wc));

        // Reset one cycle into a fill of seg1
        send_word(1'b0, 14'd7, 16'h0000, st);
        tick(6);
        check("pre_rst_max_idx", max_idx, {15'd32767, 15'd15});
        fill_req = 1'b1; fill_segment = 1'b1; fill_value = 8'hAA;
        @(posedge clk);
        #1 fill_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("fill1_first_write", {bram_we, bram_addr, bram_din}, {1'b1, 16'h8000, 8'hAA});
        rst = 1'b1;
        #1;
        check("midfill_rst_we", bram_we, 0);
        check("midfill_rst_busy", fill_busy, 0);
        check("midfill_rst_max", max_idx, 0);
        check("midfill_rst_wc", write_count, 0);
        check("midfill_rst_ready", wr_ready, 0);
        wq.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick(4);
        check("no_write_after_rst", wq.size(), 0);
        exp_wc = 0;

        // Normal write after release
        send_word(1'b0, 14'd1, 16'hCAFE, st);
        @(negedge clk); check("post_rst_c0_we", bram_we, 0);
        @(negedge clk); check("post_rst_c1_we", bram_we, 0);
        @(negedge clk); check("post_rst_lo", {bram_we, bram_addr, bram_din}, {1'b1, 16'h0002, 8'hFE});
        @(negedge clk); check("post_rst_hi", {bram_we, bram_addr, bram_din}, {1'b1, 16'h0003, 8'hCA});
        check("post_rst_max_idx", max_idx, {15'd0, 15'd3});
        exp_wc += 2;
        tick(2);

        // Six-word burst to seg1: back-to-back writes with no gaps
        wq.delete();
        for (int k = 0; k < 6; k++) begin
            send_word(1'b1, 14'(k), {8'(8'hB0 + k), 8'(8'hA0 + k)}, st);
        end
        tick(20);
        check("burst6_count", wq.size(), 12);
        gap = (wq.size() >= 12) ? 32'(wq[11].stamp - wq[0].stamp) : 32'hFFFF_FFFF;
        check("burst6_no_gaps", gap, 11);
        errs = 0;
        for (int j = 0; j < wq.size() && j < 12; j++) begin
            ea = {1'b1, 15'(j)};
            ed = (j % 2 == 0) ? 8'(8'hA0 + j / 2) : 8'(8'hB0 + j / 2);
            if (wq[j].addr !== ea || wq[j].din !== ed) errs++;
        end
        check("burst6_data", errs, 0);
        check("burst6_max_idx", max_idx, {15'd11, 15'd3});
        exp_wc += 12;
        check("wc_after_burst6", write_count, wc_exp(exp_wc));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
